fifo_ctrl_1024_64: RTL and testbench

FIFO_CTRL_1024_64 -- requirements
Module: fifo_ctrl_1024_64

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr_1024.sv | 27 ++
 rtl/ram_syn_dual_1024_64.sv | 31 +++
 rtl/fifo_ctrl_1024_64.sv | 163 ++++++++++++++++
 tb/tb_fifo_ctrl_1024_64.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and occupancy state for the 1024x64 FIFO controller.
// Imported by the controller, its pointer and the RAM model.
package fifo_pkg;

  localparam int RAM_WIDTH = 64;
  localparam int RAM_ADDR  = 10;
  localparam int RAM_DEPTH = 1024;
  localparam int AF_LEVEL  = 1020;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fifo_ptr_1024.sv
// Wrapping RAM pointer with increment enable.
// Steps DEPTH-1 -> 0 with no gap; sync active-high reset.
module fifo_ptr_1024 #(
  parameter int AW    = fifo_pkg::RAM_ADDR,
  parameter int DEPTH = fifo_pkg::RAM_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_syn_dual_1024_64.sv
// Simple dual-port synchronous RAM, one write and one read port.
// Read data appears the cycle after a sampled read enable.
module ram_syn_dual_1024_64 #(
  parameter int W = fifo_pkg::RAM_WIDTH,
  parameter int A = fifo_pkg::RAM_ADDR
) (
  input  logic         i_clk,
  input  logic         i_cs,
  input  logic         i_we,
  input  logic [A-1:0] i_wr_addr,
  input  logic [W-1:0] i_din,
  input  logic         i_re,
  input  logic [A-1:0] i_rd_addr,
  output logic [W-1:0] o_dout
);

  logic [W-1:0] r_mem [2**A];
  logic [W-1:0] r_dout;

  always_ff @(posedge i_clk) begin
    if (i_cs && i_we) begin
      r_mem[i_wr_addr] <= i_din;
    end
    if (i_cs && i_re) begin
      r_dout <= r_mem[i_rd_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/fifo_ctrl_1024_64.sv
// FIFO controller driving an external 1024x64 dual-port RAM.
// Occupancy FSM, count, sticky error flags, 1-cycle read.
module fifo_ctrl_1024_64 #(
  parameter int RAM_WIDTH = fifo_pkg::RAM_WIDTH,
  parameter int RAM_ADDR  = fifo_pkg::RAM_ADDR,
  parameter int RAM_DEPTH = fifo_pkg::RAM_DEPTH,
  parameter int AF_LEVEL  = fifo_pkg::AF_LEVEL
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [RAM_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [RAM_WIDTH-1:0] pop_data,
  output logic                 pop_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [RAM_ADDR:0]    count,
  output logic                 overflow,
  output logic                 underflow,
  output logic [RAM_ADDR-1:0]  ram_wr_addr,
  output logic [RAM_ADDR-1:0]  ram_rd_addr,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic                 ram_write_en,
  output logic                 ram_read_en,
  output logic                 ram_chip_select,
  input  logic [RAM_WIDTH-1:0] ram_data_out
);

  import fifo_pkg::*;

  localparam int CW = RAM_ADDR + 1;
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_TOP = CW'(RAM_DEPTH - 1);
  localparam logic [CW-1:0] C_AF  = CW'(AF_LEVEL);

  occ_state_e r_state;

  logic          r_full;
  logic          r_empty;
  logic          r_af;
  logic          r_ovf;
  logic          r_udf;
  logic          r_vld;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_cnt_nxt;

  logic w_push_ok;
  logic w_pop_ok;
  logic w_push_rej;
  logic w_pop_rej;

  logic [RAM_ADDR-1:0] w_wr_ptr;
  logic [RAM_ADDR-1:0] w_rd_ptr;

  assign w_push_ok  = ~reset & push & ~r_full;
  assign w_pop_ok   = ~reset & pop & ~r_empty;
  assign w_push_rej = ~reset & push & r_full;
  assign w_pop_rej  = ~reset & pop & r_empty;

  fifo_ptr_1024 #(
    .AW    (RAM_ADDR),
    .DEPTH (RAM_DEPTH)
  ) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .i_inc (w_push_ok),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr_1024 #(
    .AW    (RAM_ADDR),
    .DEPTH (RAM_DEPTH)
  ) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .i_inc (w_pop_ok),
    .o_ptr (w_rd_ptr)
  );

  always_comb begin
    w_cnt_nxt = r_count;
    unique case (1'b1)
      (w_push_ok & ~w_pop_ok): w_cnt_nxt = r_count + C_ONE;
      (w_pop_ok & ~w_push_ok): w_cnt_nxt = r_count - C_ONE;
      default: ;
    endcase
  end

  // Flags are registered together with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_count <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      r_af    <= (w_cnt_nxt >= C_AF);
      unique case (r_state)
        S_EMPTY: begin
          if (w_push_ok) begin
            r_state <= S_PART;
            r_empty <= 1'b0;
          end
        end
        S_PART: begin
          if (w_push_ok && !w_pop_ok &&
              r_count == C_TOP) begin
            r_state <= S_FULL;
            r_full  <= 1'b1;
          end else if (w_pop_ok && !w_push_ok &&
                       r_count == C_ONE) begin
            r_state <= S_EMPTY;
            r_empty <= 1'b1;
          end
        end
        S_FULL: begin
          if (w_pop_ok) begin
            r_state <= S_PART;
            r_full  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_empty <= 1'b1;
          r_full  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_push_rej;
      r_udf <= r_udf | w_pop_rej;
      r_vld <= w_pop_ok;
    end
  end

  // Gated so a read landing in a reset cycle is never reported.
  assign pop_valid       = r_vld & ~reset;
  assign pop_data        = ram_data_out;
  assign full            = r_full;
  assign empty           = r_empty;
  assign almost_full     = r_af;
  assign count           = r_count;
  assign overflow        = r_ovf;
  assign underflow       = r_udf;
  assign ram_wr_addr     = w_wr_ptr;
  assign ram_rd_addr     = w_rd_ptr;
  assign ram_data_in     = push_data;
  assign ram_write_en    = w_push_ok;
  assign ram_read_en     = w_pop_ok;
  assign ram_chip_select = ~reset;

endmodule

// File: tb/tb_fifo_ctrl_1024_64.sv
// Bench for fifo_ctrl_1024_64 with the dual-port RAM model.
// Vector table, corner sequences and a data scoreboard.
module tb_fifo_ctrl_1024_64;

  logic        clock;
  logic        reset;
  logic        push;
  logic [63:0] push_data;
  logic        pop;
  logic [63:0] pop_data;
  logic        pop_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic [10:0] count;
  logic        overflow;
  logic        underflow;
  logic [9:0]  ram_wr_addr;
  logic [9:0]  ram_rd_addr;
  logic [63:0] ram_data_in;
  logic        ram_write_en;
  logic        ram_read_en;
  logic        ram_chip_select;
  logic [63:0] ram_data_out;

  fifo_ctrl_1024_64 dut (
    .clock           (clock),
    .reset           (reset),
    .push            (push),
    .push_data       (push_data),
    .pop             (pop),
    .pop_data        (pop_data),
    .pop_valid       (pop_valid),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .count           (count),
    .overflow        (overflow),
    .underflow       (underflow),
    .ram_wr_addr     (ram_wr_addr),
    .ram_rd_addr     (ram_rd_addr),
    .ram_data_in     (ram_data_in),
    .ram_write_en    (ram_write_en),
    .ram_read_en     (ram_read_en),
    .ram_chip_select (ram_chip_select),
    .ram_data_out    (ram_data_out)
  );

  ram_syn_dual_1024_64 u_ram (
    .i_clk     (clock),
    .i_cs      (ram_chip_select),
    .i_we      (ram_write_en),
    .i_wr_addr (ram_wr_addr),
    .i_din     (ram_data_in),
    .i_re      (ram_read_en),
    .i_rd_addr (ram_rd_addr),
    .o_dout    (ram_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        p;
    logic        q;
    logic [63:0] d;
    logic        e_we;
    logic        e_re;
    logic [9:0]  e_wa;
    logic [10:0] e_cnt;
    logic        e_empty;
    logic        e_udf;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb[$];
  int          m_count;
  logic        m_ovf;
  logic        m_udf;
  logic        m_pend;
  logic [9:0]  m_wp;
  logic [9:0]  m_rp;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_pend  = 1'b0;
    m_wp    = '0;
    m_rp    = '0;
  endtask

  task automatic cycle(input  logic        p,
                       input  logic        q,
                       input  logic [63:0] d,
                       output logic        o_we,
                       output logic        o_re,
                       output logic [9:0]  o_wa);
    logic ap;
    logic aq;
    push      = p;
    pop       = q;
    push_data = d;
    @(negedge clock);
    check("pop_valid", pop_valid, m_pend);
    if (m_pend && pop_valid) begin
      if (sb.size() == 0) check("sb_nonempty", 0, 1);
      else check("pop_data", pop_data, sb.pop_front());
    end
    check("count", count, 64'(m_count));
    check("empty", empty, m_count == 0);
    check("full", full, m_count == 1024);
    check("almost_full", almost_full, m_count >= 1020);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
    check("chip_select", ram_chip_select, 1);
    ap = p && (m_count != 1024);
    aq = q && (m_count != 0);
    check("write_en", ram_write_en, ap);
    check("read_en", ram_read_en, aq);
    if (ap) begin
      check("wr_addr", ram_wr_addr, m_wp);
      check("data_in", ram_data_in, d);
    end
    if (aq) check("rd_addr", ram_rd_addr, m_rp);
    o_we = ram_write_en;
    o_re = ram_read_en;
    o_wa = ram_wr_addr;
    if (ap) begin
      sb.push_back(d);
      m_wp = m_wp + 10'd1;
    end
    if (aq) m_rp = m_rp + 10'd1;
    m_pend  = aq;
    m_count = m_count + int'(ap) - int'(aq);
    m_ovf   = m_ovf | (p & ~ap);
    m_udf   = m_udf | (q & ~aq);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    push      = 1'b1;
    pop       = 1'b1;
    push_data = '1;
    repeat (2) begin
      @(negedge clock);
      check("rst_cs", ram_chip_select, 0);
      check("rst_we", ram_write_en, 0);
      check("rst_re", ram_read_en, 0);
      check("rst_pop_valid", pop_valid, 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    model_clear();
  endtask

  vec_t tbl[10];

  initial begin
    logic       we_o;
    logic       re_o;
    logic [9:0] wa_o;
    int         budget;

    tbl[0] = '{1, 0, 64'hA5A5_0000_0000_0001, 1, 0, 10'd0, 11'd1, 0, 0};
    tbl[1] = '{0, 1, 64'h0,                   0, 1, 10'd0, 11'd0, 1, 0};
    tbl[2] = '{0, 0, 64'h0,                   0, 0, 10'd0, 11'd0, 1, 0};
    tbl[3] = '{1, 1, 64'h1111,                1, 0, 10'd1, 11'd1, 0, 1};
    tbl[4] = '{0, 1, 64'h0,                   0, 1, 10'd0, 11'd0, 1, 1};
    tbl[5] = '{0, 1, 64'h0,                   0, 0, 10'd0, 11'd0, 1, 1};
    tbl[6] = '{1, 1, 64'h2222,                1, 0, 10'd2, 11'd1, 0, 1};
    tbl[7] = '{1, 1, 64'h3333,                1, 1, 10'd3, 11'd1, 0, 1};
    tbl[8] = '{0, 1, 64'h0,                   0, 1, 10'd0, 11'd0, 1, 1};
    tbl[9] = '{0, 0, 64'h0,                   0, 0, 10'd0, 11'd0, 1, 1};

    reset     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].p, tbl[i].q, tbl[i].d, we_o, re_o, wa_o);
      check($sformatf("v%0d_we", i), we_o, tbl[i].e_we);
      check($sformatf("v%0d_re", i), re_o, tbl[i].e_re);
      if (tbl[i].e_we) check($sformatf("v%0d_wa", i), wa_o, tbl[i].e_wa);
      check($sformatf("v%0d_cnt", i), count, tbl[i].e_cnt);
      check($sformatf("v%0d_empty", i), empty, tbl[i].e_empty);
      check($sformatf("v%0d_udf", i), underflow, tbl[i].e_udf);
    end

    do_reset();
    for (int i = 0; i < 1024; i++) begin
      cycle(1, 0, 64'(i), we_o, re_o, wa_o);
      if (i == 1018) check("af_below", almost_full, 0);
      if (i == 1019) check("af_at", almost_full, 1);
      if (i == 1022) check("not_full", full, 0);
    end
    check("fill_full", full, 1);
    check("fill_count", count, 1024);
    check("fill_ovf", overflow, 0);
    cycle(1, 0, 64'hBAD, we_o, re_o, wa_o);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 1024);
    cycle(1, 1, 64'hDEAD, we_o, re_o, wa_o);
    check("fpp_we", we_o, 0);
    check("fpp_re", re_o, 1);
    check("fpp_count", count, 1023);
    check("fpp_full", full, 0);
    check("fpp_ovf", overflow, 1);

    cycle(0, 1, 64'h0, we_o, re_o, wa_o);
    do_reset();
    check("mid_count", count, 0);
    check("mid_empty", empty, 1);
    check("mid_ovf", overflow, 0);
    check("mid_udf", underflow, 0);

    cycle(1, 1, 64'h5555_AAAA_0000_0001, we_o, re_o, wa_o);
    check("epp_count", count, 1);
    check("epp_udf", underflow, 1);
    check("epp_empty", empty, 0);
    for (int i = 0; i < 2000; i++) begin
      logic p;
      logic q;
      if (i < 1000) begin
        p = ($urandom_range(99) < 80);
        q = ($urandom_range(99) < 50);
      end else begin
        p = ($urandom_range(99) < 50);
        q = ($urandom_range(99) < 80);
      end
      cycle(p, q, {$urandom, $urandom}, we_o, re_o, wa_o);
    end
    budget = 1100;
    while (m_count > 0 && budget > 0) begin
      cycle(0, 1, 64'h0, we_o, re_o, wa_o);
      budget--;
    end
    cycle(0, 0, 64'h0, we_o, re_o, wa_o);
    check("drain_budget", budget > 0, 1);
    check("sb_drained", sb.size(), 0);
    check("drain_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
